// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with registered read ports and an in-flight producer scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       writereg_i,
  input  logic [ADDR_W-1:0]          rd_i,
  input  logic [DATA_W-1:0]          writedata_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rs_i,
  output logic [NUM_RD*DATA_W-1:0]   readdata_o,
  output logic [NUM_RD-1:0]          rs_busy_o,
  input  logic                       issue_valid_i,
  input  logic [ADDR_W-1:0]          issue_rd_i,
  output logic [ADDR_W:0]            busy_count_o
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] readdata_q, readdata_d;
  logic [NUM_RD-1:0]        rs_busy_q, rs_busy_d;
  logic [ADDR_W:0]          busy_count_q, busy_count_d;
  logic                     wr_en, iss_en;
  assign wr_en  = writereg_i && !(ZERO_REG && rd_i == '0);
  assign iss_en = issue_valid_i && !(ZERO_REG && issue_rd_i == '0);
  // Issue is applied after the write clear so a colliding new producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[rd_i] = 1'b0;
    if (iss_en) busy_d[issue_rd_i] = 1'b1;
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) busy_count_d = busy_count_d + (ADDR_W+1)'(busy_d[i]);
  end
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              z;
    a          = '0;
    z          = 1'b0;
    readdata_d = '0;
    rs_busy_d  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = rs_i[k*ADDR_W +: ADDR_W];
      z = ZERO_REG && a == '0;
      readdata_d[k*DATA_W +: DATA_W] = z ? '0 :
        (BYPASS && wr_en && rd_i == a) ? writedata_i : mem_q[a];
      rs_busy_d[k] = !z && busy_d[a];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q       <= '0;
      readdata_q   <= '0;
      rs_busy_q    <= '0;
      busy_count_q <= '0;
    end else begin
      if (wr_en) mem_q[rd_i] <= writedata_i;
      busy_q       <= busy_d;
      readdata_q   <= readdata_d;
      rs_busy_q    <= rs_busy_d;
      busy_count_q <= busy_count_d;
    end
  end
  assign readdata_o   = readdata_q;
  assign rs_busy_o    = rs_busy_q;
  assign busy_count_o = busy_count_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of reg_file_sb in default, no-bypass and small/no-zero-register configurations.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0, iv = 1'b0;
  logic [4:0]  rd = '0, ird = '0;
  logic [31:0] wd = '0;
  logic [9:0]  rs = '0;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rb_a, rb_b;
  logic [5:0]  cnt_a, cnt_b;
  logic        we2 = 1'b0, iv2 = 1'b0;
  logic [2:0]  rd2 = '0, ird2 = '0;
  logic [15:0] wd2 = '0;
  logic [8:0]  rs2 = '0;
  logic [47:0] rdata_c;
  logic [2:0]  rb_c;
  logic [3:0]  cnt_c;
  int vectors = 0, errs = 0;

  always #5 clk = ~clk;

  reg_file_sb u_a (
    .clk(clk), .rst_n(rst_n), .writereg_i(we), .rd_i(rd), .writedata_i(wd), .rs_i(rs),
    .readdata_o(rdata_a), .rs_busy_o(rb_a), .issue_valid_i(iv), .issue_rd_i(ird), .busy_count_o(cnt_a));
  reg_file_sb #(.BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .writereg_i(we), .rd_i(rd), .writedata_i(wd), .rs_i(rs),
    .readdata_o(rdata_b), .rs_busy_o(rb_b), .issue_valid_i(iv), .issue_rd_i(ird), .busy_count_o(cnt_b));
  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .writereg_i(we2), .rd_i(rd2), .writedata_i(wd2), .rs_i(rs2),
    .readdata_o(rdata_c), .rs_busy_o(rb_c), .issue_valid_i(iv2), .issue_rd_i(ird2), .busy_count_o(cnt_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    chk("por_rdata", rdata_a, 64'h0);
    chk("por_cnt", 64'(cnt_a), 64'h0);
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; rd = 5'(i); wd = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    we = 1'b0; iv = 1'b1; ird = 5'd2; rs = {5'd2, 5'd1};
    tick();
    chk("pre_rst_rdata", rdata_a, {32'hA5A5_0002, 32'hA5A5_0001});
    chk("pre_rst_busy", 64'(rb_a), 64'h2);
    chk("pre_rst_cnt", 64'(cnt_a), 64'h1);
    iv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rdata", rdata_a, 64'h0);
    chk("async_rst_busy", 64'(rb_a), 64'h0);
    chk("async_rst_cnt", 64'(cnt_a), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_read", rdata_a, 64'h0);
    chk("post_rst_busy", 64'(rb_a), 64'h0);

    we = 1'b1; rd = 5'd7; wd = 32'hDEAD_BEEF; rs = '0;
    tick();
    we = 1'b0; rs = {5'd7, 5'd7};
    tick();
    chk("r7_dual_a", rdata_a, {2{32'hDEAD_BEEF}});
    chk("r7_dual_b", rdata_b, {2{32'hDEAD_BEEF}});
    we = 1'b1; rd = 5'd0; wd = 32'h1234; rs = '0;
    tick();
    chk("r0_bypass_zero", rdata_a, 64'h0);
    we = 1'b0;
    tick();
    chk("r0_read_zero", rdata_a, 64'h0);

    we = 1'b1; rd = 5'd3; wd = 32'h11;
    tick();
    wd = 32'h22; rs = {5'd0, 5'd3};
    tick();
    chk("bypass_on", rdata_a, 64'h22);
    chk("bypass_off", rdata_b, 64'h11);
    we = 1'b0;
    tick();
    chk("bypass_off_next", rdata_b, 64'h22);

    iv = 1'b1; ird = 5'd5;
    tick();
    chk("sb_cnt1", 64'(cnt_a), 64'h1);
    ird = 5'd9; rs = {5'd9, 5'd5};
    tick();
    chk("sb_cnt2", 64'(cnt_a), 64'h2);
    chk("sb_busy_59", 64'(rb_a), 64'h3);
    iv = 1'b0; we = 1'b1; rd = 5'd5; wd = 32'h77; rs = {5'd5, 5'd5};
    tick();
    chk("sb_clear_busy", 64'(rb_a), 64'h0);
    chk("sb_clear_cnt", 64'(cnt_a), 64'h1);
    we = 1'b0; iv = 1'b1; ird = 5'd0; rs = {5'd0, 5'd9};
    tick();
    chk("sb_issue_r0_cnt", 64'(cnt_a), 64'h1);
    chk("sb_issue_r0_busy", 64'(rb_a), 64'h1);

    ird = 5'd4;
    tick();
    chk("col_pre_cnt", 64'(cnt_a), 64'h2);
    we = 1'b1; rd = 5'd4; wd = 32'h55; rs = {5'd4, 5'd4};
    tick();
    chk("col_cnt", 64'(cnt_a), 64'h2);
    chk("col_busy", 64'(rb_a), 64'h3);
    chk("col_bypass", rdata_a, {2{32'h55}});
    we = 1'b0; iv = 1'b0;
    tick();
    chk("col_read_b", rdata_b, {2{32'h55}});
    chk("col_busy_hold", 64'(rb_b), 64'h3);

    we2 = 1'b1; rd2 = 3'd0; wd2 = 16'hBEEF;
    tick();
    rd2 = 3'd1; wd2 = 16'h1111;
    tick();
    rd2 = 3'd2; wd2 = 16'h2222;
    tick();
    we2 = 1'b0; rs2 = {3'd2, 3'd1, 3'd0};
    tick();
    chk("sw_3port", rdata_c, {16'h2222, 16'h1111, 16'hBEEF});
    iv2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ird2 = 3'(i);
      tick();
      chk("sw_cnt_step", 64'(cnt_c), 64'(i + 1));
    end
    iv2 = 1'b0;
    tick();
    chk("sw_cnt8", 64'(cnt_c), 64'h8);
    chk("sw_busy_all", 64'(rb_c), 64'h7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor of the processor's register file: DEPTH = 2^ADDR_W registers of DATA_W bits, NUM_RD independent registered read ports, one write port, optional hardwired-zero register 0 and optional same-cycle write-to-read bypass. An integrated scoreboard tracks registers with an in-flight producer, so the issue stage can detect RAW hazards. It sits between decode/issue and writeback in the pipelined datapath.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2^ADDR_W
- NUM_RD, 2, number of read ports (>=1)
- ZERO_REG, 1, 1 = register 0 always reads 0, writes to it dropped
- BYPASS, 1, 1 = same-cycle write is visible on a read of the same index
- clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- writereg  in  1  write enable
- rd  in  ADDR_W  write index
- writedata  in  DATA_W  write data
- rs  in  NUM_RD*ADDR_W  read indices; port k = rs[k*ADDR_W +: ADDR_W]
- readdata  out  NUM_RD*DATA_W  registered read data; port k = readdata[k*DATA_W +: DATA_W]
- rs_busy  out  NUM_RD  registered scoreboard bit for each port's sampled index
- issue_valid  in  1  marks issue_rd as having a new in-flight producer
- issue_rd  in  ADDR_W  destination of the issued instruction
- busy_count  out  ADDR_W+1  number of registers currently marked busy

## Operation
- Storage: DEPTH x DATA_W array, busy vector of DEPTH bits.
- Reset (reset low, asynchronous): all array entries 0, busy all 0, readdata 0, rs_busy 0, busy_count 0. Held while low; first update on first rising edge after release.
- Write: on edge with writereg=1, array[rd] <= writedata; busy[rd] cleared. If ZERO_REG=1 and rd=0: no array change, busy[0] untouched (always 0).
- Issue: on edge with issue_valid=1, busy[issue_rd] set. ZERO_REG=1 and issue_rd=0: ignored.
- Same edge, writereg and issue_valid with rd = issue_rd: data written, busy ends SET (new producer wins).
- Read, each port k independently, on every edge:
  - ZERO_REG=1 and rs_k=0: readdata_k <= 0, rs_busy_k <= 0.
  - BYPASS=1, writereg=1, rd=rs_k (and not dropped): readdata_k <= writedata.
  - otherwise readdata_k <= array[rs_k] (pre-edge contents).
  - rs_busy_k <= post-edge busy[rs_k], i.e. includes this edge's issue set and write clear.
- Multiple ports reading the same index return identical data/busy.
- busy_count <= popcount of post-edge busy vector; range 0..DEPTH-1 when ZERO_REG=1, 0..DEPTH otherwise; never wraps.
- No-op cycle (writereg=0, issue_valid=0): array and busy unchanged; read ports still resample.

## Timing
- Read latency: 1 cycle, rs sampled at edge N, readdata/rs_busy valid after edge N until edge N+1.
- Write latency: written value visible to a read sampled at edge N (BYPASS=1) or N+1 (BYPASS=0).
- Scoreboard latency: issue at edge N -> rs_busy high for reads sampled at edge N onward; write at edge N -> rs_busy low for reads sampled at edge N onward (unless re-issued same edge).
- busy_count reflects post-edge state, same cycle as rs_busy.
- Reset assertion mid-cycle: outputs go to 0 without waiting for clock; in-flight write/issue lost.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset: drive writes to regs 1..31 with 0xA5A5_0000+i, pulse reset low mid-cycle -> readdata, rs_busy, busy_count 0 immediately; subsequent reads of any index return 0.
- Write/read: write 0xDEAD_BEEF to r7, next edge read rs0=7, rs1=7 -> both ports 0xDEAD_BEEF one cycle later; write 0x1234 to r0 (ZERO_REG=1) -> read r0 returns 0.
- Bypass: r3 holds 0x11, same edge write 0x22 to r3 and read r3 -> 0x22 with BYPASS=1, 0x11 with BYPASS=0 (0x22 on following read).
- Scoreboard: issue r5, r9 on two edges -> busy_count 1 then 2, read r5 gives rs_busy=1; write r5 -> rs_busy=0, busy_count 1; issue r0 -> busy_count unchanged.
- Collision: r4 busy, same edge writereg rd=4 data 0x55 and issue_valid issue_rd=4 -> r4 reads 0x55, rs_busy=1, busy_count unchanged.
- Parameter sweep: DATA_W=16, ADDR_W=3, NUM_RD=3, ZERO_REG=0 -> r0 writable (0xBEEF readback), issue all 8 -> busy_count=8, three ports read distinct registers correctly in the same cycle.
